ctl_trace_buffer: RTL and testbench
===================================

// Module: ctl_trace_buffer
// PURPOSE
//  Parametrised control-signal trace unit for the board debug display. Takes the packed
//  controller snapshot (bus from the controller dot-packer) on every core step strobe and
//  stores it in a DEPTH-entry ring buffer. Supports a mask/value trigger with post-trigger
//  count, manual freeze and back/forward browsing of frozen history. Drives the LED dot bus
//  live or from history.
// PARAMETERS
//  WIDTH     64  snapshot / display width in bits
//  DEPTH     16  ring entries; power of 2, >=2; ADDR_W = $clog2(DEPTH)
//  POST_TRIG 4   samples stored after the trigger sample before auto-freeze (0..DEPTH-1)
// PORTS
//  clock      in   1        system clock
//  reset      in   1        asynchronous, active-high reset
//  sample_en  in   1        one-cycle strobe: capture snap_in this cycle
//  snap_in    in   WIDTH    packed controller snapshot
//  trig_mask  in   WIDTH    1 = bit participates in trigger compare
//  trig_value in   WIDTH    trigger compare value
//  arm        in   1        one-cycle pulse: LIVE -> ARMED
//  freeze     in   1        one-cycle pulse: manual freeze
//  release    in   1        one-cycle pulse: FROZEN -> LIVE
//  view_prev  in   1        one-cycle pulse: step one entry older
//  view_next  in   1        one-cycle pulse: step one entry newer
//  dots       out  WIDTH    display bus (registered)
//  state      out  2        00 LIVE, 01 ARMED, 10 POST, 11 FROZEN
//  view_off   out  ADDR_W   0 = newest stored entry
//  count      out  ADDR_W+1 valid entries, saturates at DEPTH
//  trig_hit   out  1        one-cycle pulse when trigger matches
// BEHAVIOUR
//  - Reset (async) clears: state=LIVE, wr_ptr=0, count=0, view_off=0, post_cnt=0,
//    dots=0, trig_hit=0. RAM contents are not reset. Reset mid-POST/FROZEN discards history.
//  - Write: in LIVE/ARMED/POST, sample_en writes snap_in at wr_ptr. wr_ptr wraps at DEPTH.
//    count increments, saturating at DEPTH. No writes in FROZEN.
//  - Match = ((snap_in ^ trig_value) & trig_mask) == 0; evaluated only on sample_en in ARMED.
//    An all-zero mask matches the first sample.
//  - LIVE: arm -> ARMED. dots <= snap_in on each sample_en, else holds.
//  - ARMED: on match, write the sample and pulse trig_hit next cycle.
//    Go to POST with post_cnt=POST_TRIG, or straight to FROZEN if POST_TRIG==0.
//  - POST: each sample_en writes and decrements post_cnt. The write that takes post_cnt
//    1->0 also moves to FROZEN. Hence exactly POST_TRIG samples follow the trigger entry.
//  - freeze in LIVE/ARMED/POST -> FROZEN next cycle. A same-cycle sample_en is still
//    written first. freeze has priority over arm and match.
//  - FROZEN: view_prev -> view_off+1, saturating at count-1. view_next -> view_off-1,
//    saturating at 0. Both in the same cycle: no change.
//    Displayed entry = RAM[(wr_ptr-1-view_off) mod DEPTH]. dots updates 1 cycle after
//    view_off changes (registered read), and 1 cycle after entering FROZEN (shows newest).
//    If count==0, dots=0.
//  - release in FROZEN -> LIVE, view_off=0, count/wr_ptr kept. dots keeps its value
//    until the next sample_en. release is ignored outside FROZEN.
//  - view_prev/view_next are ignored outside FROZEN. arm is ignored outside LIVE.
// TESTING
//  1 reset; 3 sample_en with snap 0x11,0x22,0x33 -> dots=0x33 in LIVE, count=3, state=00.
//  2 DEPTH=16: 20 samples 1..20, freeze -> count=16, dots=20. 15x view_prev -> dots=5.
//    A 16th view_prev holds view_off=15, dots=5.
//  3 mask=0xFF, value=0x07, arm; samples 1..12 -> trig_hit after sample 7, freeze after 11.
//    dots=11, view_prev x4 -> 7.
//  4 freeze and sample_en(0xAA) in the same cycle while ARMED -> FROZEN, dots=0xAA.
//  5 freeze with count=0 -> dots=0; view_prev/next keep view_off=0. release -> LIVE.
//  6 reset asserted mid-POST -> state=00, count=0, dots=0 asynchronously. No trig_hit after.

Source files
------------

// File: rtl/ctl_trace_buffer.sv
// ctl_trace_buffer: ring-buffer trace of packed controller snapshots with a
// mask/value trigger, post-trigger capture, manual freeze and history browsing
// for the LED dot display.
//
// state | meaning
// LIVE   | capturing, display follows each new sample
// ARMED  | capturing, waiting for a trigger match
// POST   | capturing the remaining post-trigger samples
// FROZEN | no capture, display shows stored history at view_off
//
// The release pulse is named release_req because "release" is a reserved word.
module ctl_trace_buffer #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [WIDTH-1:0]  snap_in,
    input  logic [WIDTH-1:0]  trig_mask,
    input  logic [WIDTH-1:0]  trig_value,
    input  logic              arm,
    input  logic              freeze,
    input  logic              release_req,
    input  logic              view_prev,
    input  logic              view_next,
    output logic [WIDTH-1:0]  dots,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] view_off,
    output logic [ADDR_W:0]   count,
    output logic              trig_hit
);

    typedef enum logic [1:0] {
        ST_LIVE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_POST   = 2'b10,
        ST_FROZEN = 2'b11
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_TRIG);

    state_t            st;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              capturing;
    logic              match;
    logic              can_go_older;

    assign state        = st;
    assign capturing    = sample_en && (st != ST_FROZEN);
    assign match        = ((snap_in ^ trig_value) & trig_mask) == '0;
    assign rd_addr      = wr_ptr - ONE_A - view_off;
    assign can_go_older = ({1'b0, view_off} + ONE_C) < count;

    // Snapshot storage; contents survive reset and are only meaningful below count.
    always_ff @(posedge clock) begin
        if (capturing) begin
            mem[wr_ptr] <= snap_in;
        end
    end

    // Capture bookkeeping, trigger sequencing, browsing and the registered display.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st       <= ST_LIVE;
            wr_ptr   <= '0;
            count    <= '0;
            view_off <= '0;
            post_cnt <= '0;
            dots     <= '0;
            trig_hit <= 1'b0;
        end else begin
            trig_hit <= 1'b0;
            if (capturing) begin
                wr_ptr <= wr_ptr + ONE_A;
                dots   <= snap_in;
                if (count != DEPTH_CNT) begin
                    count <= count + ONE_C;
                end
            end
            case (st)
                ST_LIVE: begin
                    if (freeze) begin
                        st <= ST_FROZEN;
                    end else if (arm) begin
                        st <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (freeze) begin
                        st <= ST_FROZEN;
                    end else if (sample_en && match) begin
                        trig_hit <= 1'b1;
                        post_cnt <= POST_INIT;
                        st       <= (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
                    end
                end
                ST_POST: begin
                    if (freeze) begin
                        st <= ST_FROZEN;
                    end else if (sample_en) begin
                        post_cnt <= post_cnt - ONE_A;
                        if (post_cnt == ONE_A) begin
                            st <= ST_FROZEN;
                        end
                    end
                end
                default: begin
                    dots <= (count == '0) ? '0 : mem[rd_addr];
                    if (release_req) begin
                        st       <= ST_LIVE;
                        view_off <= '0;
                    end else if (view_prev && !view_next && can_go_older) begin
                        view_off <= view_off + ONE_A;
                    end else if (view_next && !view_prev && (view_off != '0)) begin
                        view_off <= view_off - ONE_A;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctl_trace_buffer.sv
// Bench for ctl_trace_buffer: queue-based history model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ctl_trace_buffer;

    localparam int WIDTH     = 64;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sample_en = 1'b0;
    logic [63:0] snap_in = '0;
    logic [63:0] trig_mask = '0;
    logic [63:0] trig_value = '0;
    logic        arm = 1'b0;
    logic        freeze = 1'b0;
    logic        release_req = 1'b0;
    logic        view_prev = 1'b0;
    logic        view_next = 1'b0;
    logic [63:0] dots;
    logic [1:0]  state;
    logic [3:0]  view_off;
    logic [4:0]  count;
    logic        trig_hit;

    int n_cmp = 0;
    int n_bad = 0;

    ctl_trace_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
        .clock(clock), .reset(reset), .sample_en(sample_en), .snap_in(snap_in),
        .trig_mask(trig_mask), .trig_value(trig_value), .arm(arm), .freeze(freeze),
        .release_req(release_req), .view_prev(view_prev), .view_next(view_next),
        .dots(dots), .state(state), .view_off(view_off), .count(count), .trig_hit(trig_hit)
    );

    always #5 clock = ~clock;

    // Model: history is a queue of stored snapshots, newest at the back.
    logic [63:0] hist[$];
    int          m_state = 0;
    int          m_view = 0;
    int          m_post = 0;
    logic [63:0] m_dots = '0;
    bit          m_hit = 1'b0;

    always @(posedge clock or posedge reset) begin
        int          ns;
        bit          hit;
        logic [63:0] nd;
        if (reset) begin
            hist.delete();
            m_state = 0;
            m_view  = 0;
            m_post  = 0;
            m_dots  = '0;
            m_hit   = 1'b0;
        end else begin
            ns  = m_state;
            hit = 1'b0;
            nd  = m_dots;
            if (m_state != 3) begin
                if (sample_en) begin
                    hist.push_back(snap_in);
                    if (hist.size() > DEPTH) void'(hist.pop_front());
                    nd = snap_in;
                end
                if (freeze) ns = 3;
                else if (m_state == 0 && arm) ns = 1;
                else if (m_state == 1 && sample_en && ((snap_in ^ trig_value) & trig_mask) == 64'd0) begin
                    hit    = 1'b1;
                    m_post = POST_TRIG;
                    ns     = (POST_TRIG == 0) ? 3 : 2;
                end else if (m_state == 2 && sample_en) begin
                    m_post = m_post - 1;
                    if (m_post == 0) ns = 3;
                end
            end else begin
                nd = (hist.size() == 0) ? 64'd0 : hist[hist.size() - 1 - m_view];
                if (release_req) begin
                    ns     = 0;
                    m_view = 0;
                end else if (view_prev && !view_next) begin
                    if (m_view + 1 < hist.size()) m_view = m_view + 1;
                end else if (view_next && !view_prev) begin
                    if (m_view > 0) m_view = m_view - 1;
                end
            end
            m_state = ns;
            m_dots  = nd;
            m_hit   = hit;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("dots", dots, m_dots);
            chk("state", 64'(state), 64'(m_state));
            chk("view_off", 64'(view_off), 64'(m_view));
            chk("count", 64'(count), 64'(hist.size()));
            chk("trig_hit", 64'(trig_hit), 64'(m_hit));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_inputs();
        sample_en = 0; arm = 0; freeze = 0; release_req = 0; view_prev = 0; view_next = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cyc();
        reset = 0;
        cyc();
    endtask

    task automatic samp(input logic [63:0] v);
        sample_en = 1; snap_in = v; cyc(); sample_en = 0;
    endtask

    task automatic p_arm();     arm = 1;         cyc(); arm = 0;         endtask
    task automatic p_freeze();  freeze = 1;      cyc(); freeze = 0;      endtask
    task automatic p_release(); release_req = 1; cyc(); release_req = 0; endtask
    task automatic p_prev();    view_prev = 1;   cyc(); view_prev = 0;   endtask
    task automatic p_next();    view_next = 1;   cyc(); view_next = 0;   endtask

    initial begin
        #1;
        do_reset();
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_dots", dots, 64'd0);

        // Live capture
        samp(64'h11); samp(64'h22); samp(64'h33);
        chk("t1_dots", dots, 64'h33);
        chk("t1_count", 64'(count), 64'd3);
        chk("t1_state", 64'(state), 64'd0);

        // Wraparound and browsing to the oldest entry
        do_reset();
        for (int i = 1; i <= 20; i++) samp(64'(i));
        p_freeze();
        cyc();
        chk("t2_count", 64'(count), 64'd16);
        chk("t2_dots_newest", dots, 64'd20);
        for (int i = 0; i < 15; i++) p_prev();
        cyc();
        chk("t2_view_oldest", 64'(view_off), 64'd15);
        chk("t2_dots_oldest", dots, 64'd5);
        p_prev();
        cyc();
        chk("t2_view_sat", 64'(view_off), 64'd15);
        chk("t2_dots_sat", dots, 64'd5);

        // Trigger with post-trigger count
        do_reset();
        trig_mask = 64'hFF; trig_value = 64'h07;
        p_arm();
        for (int i = 1; i <= 12; i++) begin
            samp(64'(i));
            if (i == 7) chk("t3_trig_hit", 64'(trig_hit), 64'd1);
            if (i == 11) chk("t3_frozen", 64'(state), 64'd3);
        end
        cyc();
        chk("t3_count", 64'(count), 64'd11);
        chk("t3_dots", dots, 64'd11);
        for (int i = 0; i < 4; i++) p_prev();
        cyc();
        chk("t3_dots_trig", dots, 64'd7);

        // Freeze with simultaneous sample while armed
        do_reset();
        p_arm();
        sample_en = 1; snap_in = 64'hAA; freeze = 1;
        cyc();
        clear_inputs();
        chk("t4_state", 64'(state), 64'd3);
        cyc();
        chk("t4_dots", dots, 64'hAA);

        // Freeze on empty history
        do_reset();
        p_freeze();
        cyc();
        chk("t5_dots", dots, 64'd0);
        p_prev();
        chk("t5_view_prev", 64'(view_off), 64'd0);
        p_next();
        chk("t5_view_next", 64'(view_off), 64'd0);
        p_release();
        chk("t5_release", 64'(state), 64'd0);

        // Asynchronous reset in the middle of post-trigger capture
        do_reset();
        trig_mask = '0;
        p_arm();
        samp(64'h5);
        chk("t6_trig_hit", 64'(trig_hit), 64'd1);
        samp(64'h6);
        chk("t6_post", 64'(state), 64'd2);
        #1 reset = 1;
        #1;
        chk("t6_async_state", 64'(state), 64'd0);
        chk("t6_async_count", 64'(count), 64'd0);
        chk("t6_async_dots", dots, 64'd0);
        cyc();
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            samp(64'(i + 40));
            chk("t6_no_trig", 64'(trig_hit), 64'd0);
        end

        // Randomized traffic
        do_reset();
        trig_mask = 64'h00F; trig_value = 64'h3;
        for (int i = 0; i < 3000; i++) begin
            sample_en   = ($urandom_range(0, 1) == 1);
            snap_in     = {$urandom(), $urandom()};
            arm         = ($urandom_range(0, 19) == 0);
            freeze      = ($urandom_range(0, 39) == 0);
            release_req = ($urandom_range(0, 14) == 0);
            view_prev   = ($urandom_range(0, 3) == 0);
            view_next   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                trig_mask  = {$urandom(), $urandom()} & 64'hF0F;
                trig_value = {$urandom(), $urandom()};
            end
            cyc();
        end
        clear_inputs();
        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
